alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit integer ALU for the single-cycle MIPS datapath.
- Result path is purely combinational: add, sub, and, or, signed less-than, pass-B, arithmetic shift right by register, logical shift left by shamt.
- NFlag carries a 32-bit status word: bit0 = overflow, bit1 = zero.
- A clocked flag register holds the last committed NFlag for the control unit.

Parameters:
- WIDTH, 32, datapath and flag width. Only 32 needs to be supported.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  synchronous active-low reset.
- x  input  32  operand A. For SAR, x[4:0] is the shift amount.
- y  input  32  operand B; the value that SAR shifts.
- ALUOp  input  3  operation select.
- shamt  input  6  immediate shift amount; only shamt[4:0] is used, by SLL.
- Flag  input  32  incoming status word.
- FlagWr  input  1  when high, NFlag is loaded into FlagQ at the next edge.
- ALUOut  output  32  combinational result.
- NFlag  output  32  combinational next status word.
- FlagQ  output  32  registered status word.

Behaviour:
- ALUOp encoding and ALUOut (combinational, zero latency, all arithmetic mod 2^32):
  - 000 ADD: x+y.
  - 001 SUB: x-y.
  - 010 AND: x&y.
  - 011 OR: x|y.
  - 100 LESS: 32'd1 if $signed(x)<$signed(y), else 0.
  - 101 B: y.
  - 110 SAR: $signed(y)>>>x[4:0], sign-filled.
  - 111 SLL: y<<shamt[4:0].
- shamt[5] is ignored. x[31:5] is ignored for SAR.
- Overflow, ADD: x[31]==y[31] && ALUOut[31]!=x[31].
- Overflow, SUB: x[31]!=y[31] && ALUOut[31]!=x[31].
- NFlag for ADD/SUB:
  - NFlag[0] = overflow.
  - NFlag[1] = (ALUOut==0).
  - The result is still driven when overflow occurs; no trap is raised.
- NFlag for all other ops: NFlag[1:0] = Flag[1:0], i.e. flags are preserved.
- NFlag[31:2] = Flag[31:2] for every op.
- No negative or carry flag is produced.
- ALUOut and NFlag are independent of clk and rst_n. X/Z-free inputs must give X-free outputs.
- FlagQ at each rising clk edge:
  - rst_n==0: FlagQ<=0. Reset takes priority over FlagWr.
  - Else if FlagWr: FlagQ<=NFlag.
  - Else FlagQ holds.
- FlagQ value after reset is 32'h0. It is not defined before the first clock edge.
- FlagQ is not fed back internally. The surrounding datapath chooses whether to drive Flag from FlagQ.

Test Plan:
- SUB x=300, y=300, Flag=0 -> ALUOut=0, NFlag=32'h2.
- ADD 100+200 -> ALUOut=300, NFlag=0.
- ADD 7fffffff+1 -> ALUOut=80000000, NFlag=1.
- SUB 100-200 -> ALUOut=ffffff9c, NFlag=0.
- SUB 70000000-90000000 -> ALUOut=e0000000, NFlag=1.
- Logic and shifts, all with Flag=0, expected NFlag=0:
  - AND 100,200 -> 0x40.
  - OR 100,200 -> 0xec.
  - LESS 100,200 -> 1.
  - B -> 200.
  - SAR x=0x790, y=12345678 -> 00001234.
  - SAR x=0x791, y=82345678 -> ffffc11a.
  - SLL shamt=6'h24, y=1 -> 00000010.
- Flag preservation: AND with Flag=a5a5a5a7 -> NFlag=a5a5a5a7. ADD 1+1 with Flag=ffffffff -> NFlag=fffffffc.
- Register:
  - rst_n=0 for one edge -> FlagQ=0.
  - Release reset, FlagWr=1, ADD 7fffffff+1 -> FlagQ=1 after the edge.
  - FlagWr=0 -> FlagQ holds.
  - rst_n=0 with FlagWr=1 -> FlagQ=0.

Source files
------------

// File: rtl/alu.sv
// 32-bit MIPS ALU: combinational result and next-status word, plus a
// write-enabled status register cleared by a synchronous active-low reset.
module alu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [2:0]       ALUOp,
   input  logic [5:0]       shamt,
   input  logic [WIDTH-1:0] Flag,
   input  logic             FlagWr,
   output logic [WIDTH-1:0] ALUOut,
   output logic [WIDTH-1:0] NFlag,
   output logic [WIDTH-1:0] FlagQ
);

   localparam logic [2:0] OpAdd  = 3'b000;
   localparam logic [2:0] OpSub  = 3'b001;
   localparam logic [2:0] OpAnd  = 3'b010;
   localparam logic [2:0] OpOr   = 3'b011;
   localparam logic [2:0] OpLess = 3'b100;
   localparam logic [2:0] OpB    = 3'b101;
   localparam logic [2:0] OpSar  = 3'b110;
   localparam logic [2:0] OpSll  = 3'b111;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic [WIDTH-1:0] flag_d;
   logic [WIDTH-1:0] flag_q;

   assign sum  = x + y;
   assign diff = x - y;

   // Signed overflow: result sign disagrees with x when operand signs permit it.
   assign add_ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
   assign sub_ovf = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);

   always_comb begin
      ALUOut = '0;
      NFlag  = Flag;
      case (ALUOp)
         OpAdd: begin
            ALUOut   = sum;
            NFlag[0] = add_ovf;
            NFlag[1] = (sum == '0);
         end
         OpSub: begin
            ALUOut   = diff;
            NFlag[0] = sub_ovf;
            NFlag[1] = (diff == '0);
         end
         OpAnd:  ALUOut = x & y;
         OpOr:   ALUOut = x | y;
         OpLess: ALUOut = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
         OpB:    ALUOut = y;
         OpSar:  ALUOut = $unsigned($signed(y) >>> x[4:0]);
         OpSll:  ALUOut = y << shamt[4:0];
         default: ALUOut = '0;
      endcase
   end

   assign flag_d = FlagWr ? NFlag : flag_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flag_q <= '0;
      end else begin
         flag_q <= flag_d;
      end
   end

   assign FlagQ = flag_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed test-plan vectors, then randomized
// vectors against an arithmetic reference model and a model of the status register.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [31:0] x;
   logic [31:0] y;
   logic [2:0]  ALUOp;
   logic [5:0]  shamt;
   logic [31:0] Flag;
   logic        FlagWr;
   logic [31:0] ALUOut;
   logic [31:0] NFlag;
   logic [31:0] FlagQ;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] exp_q;
   bit          have_q = 1'b0;

   alu #(.WIDTH(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (x),
      .y     (y),
      .ALUOp (ALUOp),
      .shamt (shamt),
      .Flag  (Flag),
      .FlagWr(FlagWr),
      .ALUOut(ALUOut),
      .NFlag (NFlag),
      .FlagQ (FlagQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Reference model: signed arithmetic in 64 bits, shifts as multiply/floor-divide.
   function automatic logic [31:0] ref_out(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [5:0] sh);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint r;
      longint d;
      case (op)
         3'd0: r = sa + sb;
         3'd1: r = sa - sb;
         3'd2: r = longint'(a & b);
         3'd3: r = longint'(a | b);
         3'd4: r = (sa < sb) ? 64'd1 : 64'd0;
         3'd5: r = sb;
         3'd6: begin
            d = longint'(1) << a[4:0];
            r = (sb >= 0) ? sb / d : -((-sb + d - 1) / d);
         end
         default: r = longint'(b) * (longint'(1) << sh[4:0]);
      endcase
      return r[31:0];
   endfunction

   function automatic logic [31:0] ref_flag(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] f);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint r;
      logic [31:0] nf = f;
      if (op == 3'd0 || op == 3'd1) begin
         r = (op == 3'd0) ? sa + sb : sa - sb;
         nf[0] = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         nf[1] = (r[31:0] == 32'd0);
      end
      return nf;
   endfunction

   // Apply one vector, check combinational outputs, then clock and check FlagQ.
   task automatic step(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] sh, input logic [31:0] f,
                       input logic wr, input logic rn);
      logic [31:0] nf;
      ALUOp = op; x = a; y = b; shamt = sh; Flag = f; FlagWr = wr; rst_n = rn;
      #1;
      nf = ref_flag(op, a, b, f);
      check_eq({tag, ".out"}, ALUOut, ref_out(op, a, b, sh));
      check_eq({tag, ".nflag"}, NFlag, nf);
      @(posedge clk);
      #1;
      if (!rn) begin
         exp_q  = 32'd0;
         have_q = 1'b1;
      end else if (wr) begin
         exp_q = nf;
      end
      if (have_q) check_eq({tag, ".flagq"}, FlagQ, exp_q);
   endtask

   task automatic dir(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [5:0] sh, input logic [31:0] f,
                      input logic [31:0] eo, input logic [31:0] en);
      ALUOp = op; x = a; y = b; shamt = sh; Flag = f; FlagWr = 1'b0; rst_n = 1'b1;
      #1;
      check_eq({tag, ".out_k"}, ALUOut, eo);
      check_eq({tag, ".nflag_k"}, NFlag, en);
      step(tag, op, a, b, sh, f, 1'b0, 1'b1);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h7fffffff;
         1: return 32'h80000000;
         2: return 32'hffffffff;
         3: return 32'd0;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      x = '0; y = '0; ALUOp = '0; shamt = '0; Flag = '0; FlagWr = 1'b0; rst_n = 1'b0;

      step("reset", 3'd0, 32'd0, 32'd0, 6'd0, 32'd0, 1'b0, 1'b0);
      check_eq("reset_k", FlagQ, 32'd0);

      dir("sub_zero", 3'd1, 32'd300, 32'd300, 6'd0, 32'd0, 32'd0, 32'h2);
      dir("add", 3'd0, 32'd100, 32'd200, 6'd0, 32'd0, 32'd300, 32'd0);
      dir("add_ovf", 3'd0, 32'h7fffffff, 32'd1, 6'd0, 32'd0, 32'h80000000, 32'h1);
      dir("sub_neg", 3'd1, 32'd100, 32'd200, 6'd0, 32'd0, 32'hffffff9c, 32'd0);
      dir("sub_ovf", 3'd1, 32'h70000000, 32'h90000000, 6'd0, 32'd0, 32'he0000000, 32'h1);
      dir("and", 3'd2, 32'd100, 32'd200, 6'd0, 32'd0, 32'h40, 32'd0);
      dir("or", 3'd3, 32'd100, 32'd200, 6'd0, 32'd0, 32'hec, 32'd0);
      dir("less", 3'd4, 32'd100, 32'd200, 6'd0, 32'd0, 32'd1, 32'd0);
      dir("passb", 3'd5, 32'd100, 32'd200, 6'd0, 32'd0, 32'd200, 32'd0);
      dir("sar_pos", 3'd6, 32'h790, 32'h12345678, 6'd0, 32'd0, 32'h00001234, 32'd0);
      dir("sar_neg", 3'd6, 32'h791, 32'h82345678, 6'd0, 32'd0, 32'hffffc11a, 32'd0);
      dir("sll", 3'd7, 32'd0, 32'd1, 6'h24, 32'd0, 32'h10, 32'd0);
      dir("keep_and", 3'd2, 32'd100, 32'd200, 6'd0, 32'ha5a5a5a7, 32'h40, 32'ha5a5a5a7);
      dir("keep_add", 3'd0, 32'd1, 32'd1, 6'd0, 32'hffffffff, 32'd2, 32'hfffffffc);

      step("reg_rst", 3'd0, 32'd0, 32'd0, 6'd0, 32'd0, 1'b0, 1'b0);
      step("reg_wr", 3'd0, 32'h7fffffff, 32'd1, 6'd0, 32'd0, 1'b1, 1'b1);
      check_eq("reg_wr_k", FlagQ, 32'h1);
      step("reg_hold", 3'd1, 32'd5, 32'd5, 6'd0, 32'd0, 1'b0, 1'b1);
      check_eq("reg_hold_k", FlagQ, 32'h1);
      step("reg_rst_pri", 3'd1, 32'd5, 32'd5, 6'd0, 32'd0, 1'b1, 1'b0);
      check_eq("reg_rst_pri_k", FlagQ, 32'h0);

      for (int i = 0; i < 400; i++) begin
         step("rand", 3'($urandom_range(0, 7)), pick(), pick(), 6'($urandom), $urandom,
              1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
